mem_responder: RTL and testbench
================================

# mem_responder

Word-organised RAM responder sitting on the memory side of the multicycle CPU's data/instruction port: it accepts the CPU's read and write strobes, inserts a programmable number of wait states, then commits the write or returns the read word. It serves as the behavioural memory in CPU-level benches and as the on-chip RAM in the top-level wrapper. A sticky error flag reports illegal accesses.

## Interface
- ADDR_WIDTH, 10, word-index bits; capacity 2**ADDR_WIDTH 32-bit words
- BASE_ADDR, 32'hBFC0_0000, byte address mapped to word 0
- WAIT_CYCLES, 2, wait states inserted per access (0..15 legal)
- INIT_FILE, "", hex image loaded into the array at time zero when non-empty
- clk_i  input  1  clock; all state changes on rising edge
- reset_i  input  1  reset, synchronous and active-high
- address_i  input  32  byte address of request
- read_i  input  1  read request, held until completion
- write_i  input  1  write request, held until completion
- byteenable_i  input  4  write lane enables; bit i covers bits 8i+7:8i
- writedata_i  input  32  write data
- waitrequest_o  output  1  high while a pending request must stall
- readdata_o  output  32  read result, valid when waitrequest_o low during read
- error_o  output  1  sticky illegal-access flag

## Operation
- States: IDLE, WAIT, DONE; 4-bit wait counter.
- IDLE: if read_i|write_i, latch address, writedata, byteenable, kind; counter <= WAIT_CYCLES-1; go WAIT (WAIT_CYCLES>0) or DONE (WAIT_CYCLES=0) and perform the access on that same edge.
- WAIT: if read_i and write_i both low, abort to IDLE (no commit). Else if counter==0 go DONE and perform access on that edge; else decrement.
- Access (on entry to DONE): word index = (addr - BASE_ADDR) >> 2, 32-bit unsigned subtraction. Legal iff addr >= BASE_ADDR, index < 2**ADDR_WIDTH, addr[1:0]==0, and not (read and write).
- Legal write: update only enabled byte lanes; byteenable 4'b0000 completes with no change. Legal read: readdata_o <= full word (byteenable ignored).
- Illegal: error_o <= 1, array unchanged, readdata_o <= 32'h0; transaction still completes normally.
- DONE: unconditional return to IDLE next edge; new request is only sampled in IDLE.
- waitrequest_o = (read_i|write_i) && state != DONE (combinational); 0 when no request.
- readdata_o holds its value until the next read completion.

## Timing
- Reset values: state IDLE, counter 0, waitrequest_o 0 (no request) / 1 (request present), readdata_o 32'h0, error_o 0. Array contents not cleared.
- Reset during WAIT: in-flight write never committed; state IDLE next cycle.
- Latency: request first seen at edge k; DONE reached after edge k+WAIT_CYCLES; waitrequest_o low in cycle WAIT_CYCLES+1 after assertion; total request duration WAIT_CYCLES+2 cycles.
- Back-to-back: requester may keep strobe high through DONE; next request latched at following IDLE edge, giving one idle (stalled) cycle between transactions.
- Changing address/data mid-request ignored (latched values used).
- error_o clears only on reset_i.

## Test plan
- WAIT_CYCLES=2: write 32'hDEADBEEF to BASE_ADDR+8, be=4'hF, then read -> waitrequest high 3 cycles, low 4th; readdata_o=32'hDEADBEEF, error_o=0.
- Partial write: be=4'b0101 data 32'h11223344 over 32'hFFFFFFFF -> read returns 32'hFF22FF44.
- Illegal: read BASE_ADDR+2, read BASE_ADDR-4, read BASE_ADDR+4*2**ADDR_WIDTH, read+write together -> each completes, readdata 0, error_o=1 and stays 1 until reset.
- Abort: write starts, strobes dropped in WAIT -> state IDLE, location unchanged on readback.
- Reset in WAIT of a write -> no commit, readdata_o=0, error_o=0, waitrequest_o=0 after reset with no request.
- WAIT_CYCLES=0 back-to-back reads of words 0 and 1 -> each completes 2nd cycle, one stall cycle between, correct data.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder
// -------------
// Word-organised RAM that answers the multicycle CPU's memory port. A request
// (read_i or write_i held high) is latched in IDLE. The block then spends
// WAIT_CYCLES cycles in WAIT and performs the access on the edge that enters
// DONE. waitrequest_o drops during DONE. Illegal accesses set the sticky
// error_o flag and return zero read data.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   reset_i        synchronous, active-high reset (array contents kept)
//   address_i      byte address of the request
//   read_i         read request, held by the requester until completion
//   write_i        write request, held by the requester until completion
//   byteenable_i   write lane enables, bit i covers data bits 8i+7:8i
//   writedata_i    write data
//   waitrequest_o  high while a pending request must stall
//   readdata_o     read result, valid when waitrequest_o is low during a read
//   error_o        sticky illegal-access flag, cleared only by reset_i
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [3:0]  byteenable_i,
    input  logic [31:0] writedata_i,
    output logic        waitrequest_o,
    output logic [31:0] readdata_o,
    output logic        error_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    // A zero-wait configuration never uses the counter; keep it at zero then.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] readdata_q;
    logic        error_q;

    logic [31:0] mem_q [DEPTH];

    logic                  req;
    logic                  from_idle;
    logic                  access_en;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic                  acc_rd;
    logic                  acc_wr;
    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  legal;
    logic                  mem_wr_en;
    logic                  unused_off;

    assign req = read_i | write_i;

    // With zero wait states the access happens on the very edge that samples
    // the request in IDLE, so the live inputs are used instead of the latches.
    assign from_idle = (state_q == S_IDLE);
    assign acc_addr  = from_idle ? address_i    : addr_q;
    assign acc_wdata = from_idle ? writedata_i  : wdata_q;
    assign acc_be    = from_idle ? byteenable_i : be_q;
    assign acc_rd    = from_idle ? read_i       : rd_q;
    assign acc_wr    = from_idle ? write_i      : wr_q;

    // Asserted exactly on the edge that moves the FSM into DONE.
    assign access_en = req &&
                       (((state_q == S_IDLE) && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0)));

    // Unsigned 32-bit offset; an address below BASE_ADDR wraps high and is
    // rejected by the explicit compare as well as the range check.
    assign off        = acc_addr - BASE_ADDR;
    assign idx        = off[ADDR_WIDTH+1:2];
    assign unused_off = ^off[1:0];
    assign legal      = (acc_addr >= BASE_ADDR) &&
                        (off[31:ADDR_WIDTH+2] == '0) &&
                        (acc_addr[1:0] == 2'b00) &&
                        !(acc_rd && acc_wr);

    // Reset suppresses the commit so an in-flight write never lands.
    assign mem_wr_en = access_en && legal && acc_wr && !reset_i;

    always_ff @(posedge clk_i) begin
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem_q[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            readdata_q <= 32'h0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= address_i;
                        wdata_q <= writedata_i;
                        be_q    <= byteenable_i;
                        rd_q    <= read_i;
                        wr_q    <= write_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (access_en) begin
                if (!legal) begin
                    error_q    <= 1'b1;
                    readdata_q <= 32'h0;
                end else if (acc_rd) begin
                    readdata_q <= mem_q[idx];
                end
            end
        end
    end

    assign waitrequest_o = req && (state_q != S_DONE);
    assign readdata_o    = readdata_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and one
// with zero wait states, driven from a single linear sequence of steps.
module tb_mem_responder;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;

    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        wreq, err;
    logic [31:0] rdata;

    logic        rd0, wr0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        wreq0, err0;
    logic [31:0] rdata0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(2),
        .INIT_FILE  ("")
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .address_i    (addr),
        .read_i       (rd),
        .write_i      (wr),
        .byteenable_i (be),
        .writedata_i  (wdata),
        .waitrequest_o(wreq),
        .readdata_o   (rdata),
        .error_o      (err)
    );

    mem_responder #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(0),
        .INIT_FILE  ("")
    ) dut0 (
        .clk_i        (clk),
        .reset_i      (rst),
        .address_i    (addr0),
        .read_i       (rd0),
        .write_i      (wr0),
        .byteenable_i (be0),
        .writedata_i  (wdata0),
        .waitrequest_o(wreq0),
        .readdata_o   (rdata0),
        .error_o      (err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the two-wait instance idle; returns at
    // posedge+1 after the DONE->IDLE edge with strobes dropped.
    task automatic xfer(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input string tag);
        rd = r; wr = w; addr = a; be = b; wdata = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "/wait"}, 32'(wreq), (i < 3) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic xfer0(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, input string tag);
        rd0 = r; wr0 = w; addr0 = a; be0 = b; wdata0 = d;
        @(negedge clk);
        chk({tag, "/wait_c1"}, 32'(wreq0), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "/wait_c2"}, 32'(wreq0), 32'd0);
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values, with and without a request present.
        @(negedge clk);
        chk("rst/wait_noreq", 32'(wreq), 32'd0);
        chk("rst/rdata", rdata, 32'h0);
        chk("rst/err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rd = 1'b1;
        @(negedge clk);
        chk("rst/wait_req", 32'(wreq), 32'd1);
        @(posedge clk); #1;
        rd = 1'b0;
        rst = 1'b0;

        // Full write then read.
        xfer(1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'hDEADBEEF, "wr8");
        xfer(1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'h0, "rd8");
        chk("rd8/data", rdata, 32'hDEADBEEF);
        chk("rd8/err", 32'(err), 32'd0);

        // Partial write, then an all-lanes-off write that must change nothing.
        xfer(1'b0, 1'b1, BASE + 32'd12, 4'hF, 32'hFFFFFFFF, "wr12");
        xfer(1'b0, 1'b1, BASE + 32'd12, 4'b0101, 32'h11223344, "wr12p");
        xfer(1'b1, 1'b0, BASE + 32'd12, 4'hF, 32'h0, "rd12");
        chk("rd12/partial", rdata, 32'hFF22FF44);
        xfer(1'b0, 1'b1, BASE + 32'd12, 4'b0000, 32'h0, "wr12z");
        xfer(1'b1, 1'b0, BASE + 32'd12, 4'hF, 32'h0, "rd12b");
        chk("rd12/be0", rdata, 32'hFF22FF44);

        // Top word of the array is legal.
        xfer(1'b0, 1'b1, BASE + 32'hFFC, 4'hF, 32'h0BADF00D, "wrtop");
        xfer(1'b1, 1'b0, BASE + 32'hFFC, 4'hF, 32'h0, "rdtop");
        chk("rdtop/data", rdata, 32'h0BADF00D);
        chk("rdtop/err", 32'(err), 32'd0);

        // Address/data changed after the request is latched are ignored.
        rd = 1'b0; wr = 1'b1; addr = BASE + 32'd20; be = 4'hF; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        addr = BASE + 32'd24; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        wr = 1'b0;
        xfer(1'b1, 1'b0, BASE + 32'd20, 4'hF, 32'h0, "rd20");
        chk("midchg/data", rdata, 32'hCAFEF00D);

        // Abort: strobes dropped in WAIT, no commit.
        rd = 1'b0; wr = 1'b1; addr = BASE + 32'd8; be = 4'hF; wdata = 32'h0;
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        chk("abort/wait", 32'(wreq), 32'd0);
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, "rdab");
        chk("abort/data", rdata, 32'hDEADBEEF);

        // Reset while a write sits in WAIT: held across the would-be commit edge.
        wr = 1'b1; addr = BASE + 32'd8; be = 4'hF; wdata = 32'h12345678;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("rstw/wait", 32'(wreq), 32'd0);
        chk("rstw/rdata", rdata, 32'h0);
        chk("rstw/err", 32'(err), 32'd0);
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, "rdrst");
        chk("rstw/data", rdata, 32'hDEADBEEF);

        // Illegal accesses, each followed by a legal read so the zero is visible.
        xfer(1'b1, 1'b0, BASE + 32'd2, 4'hF, 32'h0, "ill_mis");
        chk("ill_mis/data", rdata, 32'h0);
        chk("ill_mis/err", 32'(err), 32'd1);
        xfer(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, "rd8b");
        chk("rd8b/data", rdata, 32'hDEADBEEF);
        chk("rd8b/err_sticky", 32'(err), 32'd1);
        xfer(1'b1, 1'b0, BASE - 32'd4, 4'hF, 32'h0, "ill_lo");
        chk("ill_lo/data", rdata, 32'h0);
        xfer(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, "rd8c");
        xfer(1'b1, 1'b0, BASE + 32'h1000, 4'hF, 32'h0, "ill_hi");
        chk("ill_hi/data", rdata, 32'h0);
        xfer(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, "rd8d");
        xfer(1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'h0, "ill_rw");
        chk("ill_rw/data", rdata, 32'h0);
        xfer(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, "rd8e");
        chk("ill_rw/nocommit", rdata, 32'hDEADBEEF);
        chk("ill/err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ill/err_cleared", 32'(err), 32'd0);
        @(posedge clk); #1;

        // Zero-wait instance: preload two words, then back-to-back reads.
        xfer0(1'b0, 1'b1, BASE, 4'hF, 32'hA5A50001, "z_wr0");
        xfer0(1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'h5A5A0002, "z_wr1");
        rd0 = 1'b1; addr0 = BASE; be0 = 4'hF;
        @(negedge clk);
        chk("z_b2b/c1_wait", 32'(wreq0), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_b2b/c2_wait", 32'(wreq0), 32'd0);
        chk("z_b2b/c2_data", rdata0, 32'hA5A50001);
        @(posedge clk); #1;
        addr0 = BASE + 32'd4;
        @(negedge clk);
        chk("z_b2b/c3_stall", 32'(wreq0), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_b2b/c4_wait", 32'(wreq0), 32'd0);
        chk("z_b2b/c4_data", rdata0, 32'h5A5A0002);
        chk("z_b2b/err", 32'(err0), 32'd0);
        @(posedge clk); #1;
        rd0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
